// File: rtl/mac_ctrl.sv
// MAC sequencer/accumulator: drives the opcode counter, reads two 1-cycle-latency memories, sums a*b.
// Define MAC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module mac_ctrl #(
    parameter int N    = 6,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW+N
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [N-1:0]    n_i,
    output logic [1:0]      opc_o,
    input  logic [N-1:0]    cnt_i,
    input  logic            z_i,
    output logic            rd_o,
    output logic [N-1:0]    addr_o,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [ACCW-1:0] acc_o,
    output logic            ovf_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    localparam logic [1:0] OPC_CLR  = 2'd0;
    localparam logic [1:0] OPC_HOLD = 2'd1;
    localparam logic [1:0] OPC_DEC  = 2'd2;
    localparam logic [1:0] OPC_LOAD = 2'd3;

    state_e            state_q, state_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, vld_d;
    logic [2*DW-1:0]   prod;
    logic [ACCW:0]     sum;

    assign addr_o = cnt_i - {{(N-1){1'b0}}, 1'b1};
    assign acc_o  = acc_q;
    assign ovf_o  = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        opc_o   = OPC_HOLD;
        rd_o    = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;

        prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        sum  = {1'b0, acc_q} + {{(ACCW+1-2*DW){1'b0}}, prod};

        // Data arrives one cycle after the read strobe; accumulate it then.
        if (vld_q) begin
            if (sum[ACCW]) begin
                ovf_d = 1'b1;
`ifdef MAC_SAT_EN
                acc_d = '1;
`else
                acc_d = sum[ACCW-1:0];
`endif
            end else begin
                acc_d = sum[ACCW-1:0];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (n_i != '0) begin
                        opc_o   = OPC_LOAD;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                rd_o = 1'b1;
                if (z_i) begin
                    opc_o   = OPC_HOLD;
                    state_d = S_DRAIN;
                end else begin
                    opc_o   = OPC_DEC;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                opc_o   = OPC_CLR;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vld_d = rd_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: doc/mac_ctrl.md
Name: mac_ctrl

Overview:
- Sequencer and accumulator for the MAC project.
- Sits directly upstream of the opcode down-counter. It drives the counter's opc_i and consumes its i_o and z_o.
- Issues operand reads to two single-port ROM/RAMs that have a 1-cycle read latency, and accumulates the unsigned sum of a*b over n elements.
- Uses a start/busy/done handshake toward the top-level controller.

Parameters:
- N, 6, counter and element-count width; also the address width.
- DW, 8, operand width for a_i and b_i.
- ACCW, 2*DW+N, accumulator width. The default cannot overflow.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request; sampled only in IDLE
- n_i  in  N  element count; sampled on start accept
- opc_o  out  2  counter opcode: 0 clear, 1 hold, 2 decrement, 3 load n
- cnt_i  in  N  counter value (counter i_o)
- z_i  in  1  counter z_o; high when the counter value is 1
- rd_o  out  1  memory read strobe
- addr_o  out  N  memory read address, equal to cnt_i-1
- a_i, b_i  in  DW each  operand data, valid the cycle after rd_o
- acc_o  out  ACCW  accumulator value
- ovf_o  out  1  sticky overflow flag
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE, acc_o=0, ovf_o=0, vld_q=0, done_o=0, busy_o=0, rd_o=0. opc_o=1 in IDLE.
- IDLE:
  - opc_o=1.
  - On start_i=1 with n_i!=0: opc_o=3 (counter loads n), acc<=0, ovf<=0, next state RUN.
  - On start_i=1 with n_i==0: acc<=0, ovf<=0, next state DONE. No reads are issued.
- RUN:
  - rd_o=1, addr_o=cnt_i-1.
  - If z_i=0: opc_o=2 and stay in RUN.
  - If z_i=1: opc_o=1 and go to DRAIN.
  - Addresses are issued as n-1, n-2, ..., 0: exactly n reads, one per cycle.
- DRAIN: rd_o=0, opc_o=1, next state DONE. This state lets the last read's data be accumulated.
- DONE: done_o=1 for exactly one cycle, opc_o=0 (counter cleared), next state IDLE.
- busy_o=1 in RUN, DRAIN and DONE. start_i is ignored whenever busy_o=1.
- Data pipeline:
  - vld_q <= rd_o.
  - When vld_q=1: acc <= acc + a_i*b_i.
  - The product is unsigned, DW x DW -> 2*DW, zero-extended to ACCW+1 bits to detect carry-out.
- Carry-out of the ACCW-bit add sets ovf_o, which stays set until the next start accept or reset.
- acc_o and ovf_o hold their final values after DONE until the next accepted start.
- Latency: start accepted in cycle 0 with n=k>=1:
  - RUN occupies cycles 1..k.
  - DRAIN is cycle k+1.
  - done_o is high in cycle k+2.
  - acc_o is final at done_o.
- Latency for n=0: done_o is high in cycle 1 and acc_o=0.
- Reset mid-operation: returns immediately to reset values. Any in-flight read data is discarded (vld_q cleared). The counter is reset by the same rst_i.
- start_i held high through DONE: a new operation is accepted in the IDLE cycle after DONE. There are no back-to-back starts within DONE.
- opc_o, rd_o and addr_o are combinational from state, cnt_i and z_i. The acc, ovf, vld_q and state registers are flopped.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: on carry-out, acc saturates to all ones (2^ACCW-1) and stays saturated for the rest of the operation. ovf_o is set.
- Undefined: acc wraps modulo 2^ACCW. ovf_o is still set on the wrap.

Test Plan:
- Bench setup: the bench wires in the team's opcode counter and two behavioural ROMs with 1-cycle latency.
- n=3, a[0..2]={1,2,3}, b[0..2]={4,5,6}, start pulse in cycle 0 -> addr_o sequence 2,1,0 in cycles 1-3; opc_o sequence 3,2,2,1,1,0; done_o high only in cycle 5; acc_o=32; ovf_o=0.
- n=1, a[0]=255, b[0]=255 -> one read at address 0; done_o in cycle 3; acc_o=65025.
- n=0 start -> done_o in cycle 1; rd_o never asserted; acc_o=0; opc_o never 2.
- start_i pulses again in cycles 2 and 4 of an n=3 run -> ignored; acc_o=32; exactly one done_o pulse.
- rst_i asserted in cycle 2 of an n=3 run -> same cycle: busy_o=0, acc_o=0, rd_o=0. Next start with n=2, a={3,3}, b={3,3} -> acc_o=18.
- ACCW=16 override, n=2, a=b={255,255}: sum 130050 exceeds 65535 -> with MAC_SAT_EN, acc_o=65535 and ovf_o=1; without it, acc_o=64514 and ovf_o=1.
